digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands DIGIT bits per clock, LSB digit first.
- Carry is held in a register between digits.
- Each digit slice is a DIGIT-long ripple chain of the team's 1-bit full-adder cell, so area trades directly against latency.
- Sits in the datapath as a shared arithmetic unit behind a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand and result width in bits; WIDTH >= 2.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0. An elaboration-time check must fail otherwise.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- sub  input  1  0: sum=a+b+cin; 1: sum=a-b (computed as a+~b+1); captured on the accepting edge.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; results valid.
- sum  output  WIDTH  result; held stable until the next done.
- cout  output  1  carry out of the MSB; in sub mode 1 = no borrow.
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst=1, async): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Digit counter, carry register and operand shift registers are cleared.
- Reset asserted mid-operation aborts the operation. No done is produced, and the first post-reset cycle is IDLE.
- N = WIDTH/DIGIT digits per operation.
- FSM has two states, IDLE and RUN.
- IDLE, start=1 at edge k:
  - Latch a into the A shift register.
  - Latch (sub ? ~b : b) into the B shift register.
  - carry <= sub ? 1 : cin.
  - count <= 0; state <= RUN; busy <= 1.
- RUN, each edge:
  - Add the low DIGIT bits of A, B and carry.
  - Shift the DIGIT-bit result into the top of the result register; shift A and B right by DIGIT.
  - carry <= digit carry-out; count <= count+1.
- The last digit (count = N-1) is processed at edge k+N. At that edge:
  - sum <= full result, cout <= final carry, ovf <= c_msb_in ^ c_msb_out (internal MSB carries captured during the last digit).
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: busy is high for exactly N cycles. done is high for exactly one cycle, after edge k+N.
- done clears on the next edge unless that edge ends another operation.
- start while busy=1 is ignored: no queuing, and operands are not re-sampled.
- Back-to-back: start=1 in the cycle where done=1 is accepted (state is IDLE). busy rises on the same edge that done falls.
- sum, cout and ovf change only at the completing edge. They hold their values through subsequent IDLE and RUN cycles until the next completion.
- Changing the a, b, cin and sub inputs while busy has no effect on the running operation.
- DIGIT=WIDTH degenerates to N=1: one busy cycle, then done.
- Wrap-around: the result is modulo 2^WIDTH; the carry out appears only on cout.

Test Plan:
1. WIDTH=16, DIGIT=4, add, a=0xFFFF, b=0x0001, cin=0, start pulse -> busy for 4 cycles; done after the 4th edge; sum=0x0000, cout=1, ovf=0.
2. Add, a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then add a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
3. Sub, a=0x0005, b=0x0007, cin=1 (ignored) -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then sub a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Start during busy with different operands, and a/b toggled each cycle -> first result unaffected and no second done. Then start asserted in the done cycle -> accepted, second done exactly 4 cycles later.
5. rst asserted asynchronously between clock edges at cycle 2 of RUN -> outputs immediately 0, no done. Next start after release completes normally with correct values.
6. Parameter sweep with 1000 random a, b, cin, sub each for (WIDTH,DIGIT) = (16,1), (16,16), (12,3) and (32,8) -> sum/cout/ovf match the reference model; busy width = WIDTH/DIGIT every operation.

Source files
------------

// File: rtl/digit_serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
interface digit_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSB digit first,
// with the inter-digit carry held in a register.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  digit_serial_adder_if.slave bus
);
  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("digit_serial_adder: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic [DIGIT-1:0] dsum;
  logic [DIGIT:0]   dc;

  // Ripple chain of full-adder cells over the low digit; dc[i] is the carry into bit i.
  always_comb begin
    dc    = '0;
    dsum  = '0;
    dc[0] = carry;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dsum[i]  = a_sr[i] ^ b_sr[i] ^ dc[i];
      dc[i+1]  = (a_sr[i] & b_sr[i]) | (dc[i] & (a_sr[i] ^ b_sr[i]));
    end
    res_next = (res_sr >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub ? 1'b1 : bus.cin;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          carry  <= dc[DIGIT];
          count  <= count + 1'b1;
          // The last digit holds the MSB, so its top two ripple carries give the overflow.
          if (count == CW'(N - 1)) begin
            bus.sum  <= res_next;
            bus.cout <= dc[DIGIT];
            bus.ovf  <= dc[DIGIT-1] ^ dc[DIGIT];
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            count    <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed vectors on the 16/4 build, handshake
// corner sequences, and a random sweep across several WIDTH/DIGIT builds.
module tb_digit_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  digit_serial_adder_if #(.WIDTH(16)) bus0 ();
  digit_serial_adder_if #(.WIDTH(16)) bus1 ();
  digit_serial_adder_if #(.WIDTH(16)) bus2 ();
  digit_serial_adder_if #(.WIDTH(12)) bus3 ();
  digit_serial_adder_if #(.WIDTH(32)) bus4 ();

  digit_serial_adder #(.WIDTH(16), .DIGIT(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
  digit_serial_adder #(.WIDTH(16), .DIGIT(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  digit_serial_adder #(.WIDTH(12), .DIGIT(3))  dut3 (.clk(clk), .rst(rst), .bus(bus3));
  digit_serial_adder #(.WIDTH(32), .DIGIT(8))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain wide arithmetic and the sign-bit overflow rule.
  function automatic logic [33:0] ref_model(input int unsigned w, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin, input logic sub);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    logic [63:0] am   = {32'd0, a} & mask;
    logic [63:0] bm   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    logic [63:0] full = am + bm + {63'd0, (sub ? 1'b1 : cin)};
    logic [31:0] s    = full[31:0] & mask[31:0];
    logic        co   = full[w];
    logic        ov   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  task automatic wait_done(output logic [15:0] s, output logic co, output logic ov,
                           output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    s    = '0;
    co   = 1'b0;
    ov   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus0.done) begin
        seen = 1'b1;
        s    = bus0.sum;
        co   = bus0.cout;
        ov   = bus0.ovf;
      end else if (bus0.busy) begin
        cyc++;
      end
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, output logic [15:0] s, output logic co,
                        output logic ov, output int cyc, output bit seen);
    bus0.a     = a;
    bus0.b     = b;
    bus0.cin   = cin;
    bus0.sub   = sub;
    bus0.start = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    wait_done(s, co, ov, cyc, seen);
  endtask

  task automatic sweep_step(input string name, input int unsigned w, input int unsigned n,
                            input logic busy, input logic done, input logic [31:0] sum,
                            input logic cout, input logic ovf, input logic [31:0] a,
                            input logic [31:0] b, input logic cin, input logic sub,
                            inout int cnt, inout bit got);
    logic [33:0] exp;
    if (got) return;
    if (done) begin
      got = 1'b1;
      exp = ref_model(w, a, b, cin, sub);
      check({name, " sum"},  sum, exp[31:0]);
      check({name, " cout"}, 32'(cout), 32'(exp[32]));
      check({name, " ovf"},  32'(ovf), 32'(exp[33]));
      check({name, " busy_cycles"}, 32'(cnt), 32'(n));
    end else if (busy) begin
      cnt++;
    end
  endtask

  initial begin
    logic [15:0] s;
    logic        co, ov;
    int          cyc, ndone;
    bit          seen;
    logic [31:0] ra, rb;
    logic        rc, rs;
    int          c1, c2, c3, c4;
    bit          g1, g2, g3, g4;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    bus0.start = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.sub = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sub = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0; bus2.sub = 1'b0;
    bus3.start = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0; bus3.sub = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.sub = 1'b0;

    #3 rst = 1'b1;
    #1;
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset done", 32'(bus0.done), 32'd0);
    check("reset sum",  32'(bus0.sum),  32'd0);
    check("reset cout", 32'(bus0.cout), 32'd0);
    check("reset ovf",  32'(bus0.ovf),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, s, co, ov, cyc, seen);
      check($sformatf("vec%0d done_seen", i), 32'(seen), 32'd1);
      check($sformatf("vec%0d sum", i),  32'(s),  32'(vecs[i].sum));
      check($sformatf("vec%0d cout", i), 32'(co), 32'(vecs[i].cout));
      check($sformatf("vec%0d ovf", i),  32'(ov), 32'(vecs[i].ovf));
      check($sformatf("vec%0d busy_cycles", i), 32'(cyc), 32'd4);
      @(negedge clk);
      check($sformatf("vec%0d done_pulse_width", i), 32'(bus0.done), 32'd0);
    end

    // Start held during busy with changing operands must not disturb or queue.
    bus0.a = 16'h1111; bus0.b = 16'h2222; bus0.cin = 1'b0; bus0.sub = 1'b0; bus0.start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      bus0.a   = 16'hA5A5 ^ 16'(i * 16'h1357);
      bus0.b   = 16'h5A5A ^ 16'(i * 16'h0F0F);
      bus0.sub = 1'b1;
      bus0.cin = 1'b1;
      @(posedge clk);
    end
    #1 bus0.start = 1'b0;
    ndone = 0;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus0.done) begin
        ndone++;
        s = bus0.sum;
      end
    end
    check("busy_start done_count", 32'(ndone), 32'd1);
    check("busy_start sum", 32'(s), 32'h3333);
    check("busy_start idle_after", 32'(bus0.busy), 32'd0);

    // Back-to-back: new start accepted in the done cycle.
    run_op(16'h0100, 16'h0200, 1'b0, 1'b0, s, co, ov, cyc, seen);
    check("b2b first sum", 32'(s), 32'h0300);
    bus0.a = 16'h0050; bus0.b = 16'h0010; bus0.cin = 1'b0; bus0.sub = 1'b1; bus0.start = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    check("b2b busy_rise", 32'(bus0.busy), 32'd1);
    check("b2b done_fall", 32'(bus0.done), 32'd0);
    check("b2b sum_held",  32'(bus0.sum),  32'h0300);
    wait_done(s, co, ov, cyc, seen);
    check("b2b second done_seen", 32'(seen), 32'd1);
    check("b2b second busy_cycles", 32'(cyc), 32'd4);
    check("b2b second sum",  32'(s),  32'h0040);
    check("b2b second cout", 32'(co), 32'd1);
    check("b2b second ovf",  32'(ov), 32'd0);

    // Asynchronous abort between edges, two digits into the operation.
    bus0.a = 16'hFFFF; bus0.b = 16'h0001; bus0.cin = 1'b0; bus0.sub = 1'b0; bus0.start = 1'b1;
    @(posedge clk);
    #1 bus0.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy", 32'(bus0.busy), 32'd0);
    check("abort done", 32'(bus0.done), 32'd0);
    check("abort sum",  32'(bus0.sum),  32'd0);
    check("abort cout", 32'(bus0.cout), 32'd0);
    check("abort ovf",  32'(bus0.ovf),  32'd0);
    @(negedge clk) rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus0.done || bus0.busy) ndone++;
    end
    check("abort no_activity", 32'(ndone), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, co, ov, cyc, seen);
    check("post_abort done_seen", 32'(seen), 32'd1);
    check("post_abort sum",  32'(s),  32'h0100);
    check("post_abort cout", 32'(co), 32'd0);
    check("post_abort ovf",  32'(ov), 32'd0);
    check("post_abort busy_cycles", 32'(cyc), 32'd4);

    // Random sweep across the other builds, all running side by side.
    for (int it = 0; it < 1000; it++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      bus1.a = ra[15:0]; bus1.b = rb[15:0]; bus1.cin = rc; bus1.sub = rs; bus1.start = 1'b1;
      bus2.a = ra[15:0]; bus2.b = rb[15:0]; bus2.cin = rc; bus2.sub = rs; bus2.start = 1'b1;
      bus3.a = ra[11:0]; bus3.b = rb[11:0]; bus3.cin = rc; bus3.sub = rs; bus3.start = 1'b1;
      bus4.a = ra;       bus4.b = rb;       bus4.cin = rc; bus4.sub = rs; bus4.start = 1'b1;
      @(posedge clk);
      #1;
      bus1.start = 1'b0; bus2.start = 1'b0; bus3.start = 1'b0; bus4.start = 1'b0;
      c1 = 0; c2 = 0; c3 = 0; c4 = 0;
      g1 = 1'b0; g2 = 1'b0; g3 = 1'b0; g4 = 1'b0;
      for (int c = 0; c < 40 && !(g1 && g2 && g3 && g4); c++) begin
        @(negedge clk);
        sweep_step("w16d1", 16, 16, bus1.busy, bus1.done, 32'(bus1.sum), bus1.cout, bus1.ovf,
                   ra, rb, rc, rs, c1, g1);
        sweep_step("w16d16", 16, 1, bus2.busy, bus2.done, 32'(bus2.sum), bus2.cout, bus2.ovf,
                   ra, rb, rc, rs, c2, g2);
        sweep_step("w12d3", 12, 4, bus3.busy, bus3.done, 32'(bus3.sum), bus3.cout, bus3.ovf,
                   ra, rb, rc, rs, c3, g3);
        sweep_step("w32d8", 32, 4, bus4.busy, bus4.done, bus4.sum, bus4.cout, bus4.ovf,
                   ra, rb, rc, rs, c4, g4);
      end
      if (!(g1 && g2 && g3 && g4)) begin
        check($sformatf("sweep%0d timeout", it), {28'd0, g4, g3, g2, g1}, 32'hF);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
